// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a small combinational block through every input
// vector, holds each one for HOLD_CYCLES clocks, samples f/f2, builds the
// captured truth tables and compares them against the expected tables.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; results of the last sweep held on the outputs
// APPLY  | driving dut_in, counting hold cycles, sampling f/f2
// FINISH | one-cycle completion state; done is high for exactly this cycle

module truth_table_sweeper #(
  parameter int          N_IN        = 4,
  parameter int          HOLD_CYCLES = 4,
  parameter logic [31:0] EXP_F       = 32'h0000_0000,
  parameter logic [31:0] EXP_F2      = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   f_in,
  input  logic                   f2_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        fail_idx,
  output logic [(1<<N_IN)-1:0]   tt_f,
  output logic [(1<<N_IN)-1:0]   tt_f2
);

  localparam int TT_W = 1 << N_IN;

  // Only the low TT_W bits of the expected tables take part in the compare;
  // slicing here keeps the table index exactly N_IN bits wide.
  localparam logic [TT_W-1:0] EXP_F_TT  = EXP_F[TT_W-1:0];
  localparam logic [TT_W-1:0] EXP_F2_TT = EXP_F2[TT_W-1:0];

  // The hold counter is 8 bits, enough for the full 1..255 hold range.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t            state_q;
  logic [7:0]        hold_q;
  logic [N_IN-1:0]   idx_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              fail_valid_q;
  logic [N_IN-1:0]   fail_idx_q;
  logic [TT_W-1:0]   tt_f_q;
  logic [TT_W-1:0]   tt_f2_q;

  logic              sample_now;
  logic              last_vec;
  logic              exp_f_bit;
  logic              exp_f2_bit;
  logic              mismatch;

  // Sample strobe and per-vector compare against the expected tables.
  always_comb begin
    sample_now = (state_q == ST_APPLY) && (hold_q == HOLD_LAST);
    last_vec   = (idx_q == {N_IN{1'b1}});
    exp_f_bit  = EXP_F_TT[idx_q];
    exp_f2_bit = EXP_F2_TT[idx_q];
    mismatch   = (f_in != exp_f_bit) || (f2_in != exp_f2_bit);
  end

  // Sweep sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= 8'd0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
      tt_f_q       <= '0;
      tt_f2_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          // abort together with start wins: the sweep is not launched.
          if (start && !abort) begin
            state_q      <= ST_APPLY;
            hold_q       <= 8'd0;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
            tt_f_q       <= '0;
            tt_f2_q      <= '0;
          end
        end

        ST_APPLY: begin
          if (abort) begin
            // Partial tables and first-failure info are left for inspection.
            state_q <= ST_IDLE;
            hold_q  <= 8'd0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (sample_now) begin
            tt_f_q[idx_q]  <= f_in;
            tt_f2_q[idx_q] <= f2_in;
            if (mismatch && !fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_idx_q   <= idx_q;
            end
            hold_q <= 8'd0;
            if (!last_vec) begin
              idx_q <= idx_q + 1'b1;
            end else begin
              // The final sample is folded into pass on the same edge.
              state_q <= ST_FINISH;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= !(fail_valid_q || mismatch);
            end
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end

        ST_FINISH: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          hold_q  <= 8'd0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign dut_in     = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;
  assign tt_f       = tt_f_q;
  assign tt_f2      = tt_f2_q;

endmodule
